apb_pwm_responder: RTL and testbench

APB-style register-mapped single-channel PWM generator. It is the responder end of the bus that the motor PWM controller drives. It decodes CTRL/DIVISOR/PERIOD/DUTY writes, returns readback and slave-error responses, and generates a glitch-free PWM output from a prescaled counter. It accepts an initiator that holds psel/penable high continuously and rewrites registers every few cycles.

---
 rtl/apb_pwm_responder.sv | 132 +++++++++++++
 tb/tb_apb_pwm_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pwm_responder.sv
// APB register-mapped single-channel PWM generator.
// Registers: 0x00 CTRL {SYNC,OE,EN}, 0x04 DIVISOR, 0x08 PERIOD, 0x0C DUTY,
// 0x10 COUNT (read-only). Zero-wait-state responder; pready follows psel.
module apb_pwm_responder #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_l,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              o_pwm,
  output logic              oe_pwm,
  output logic              period_end
);

  logic             r_en, r_oe, r_sync;
  logic [CNT_W-1:0] r_div, r_per, r_duty;
  logic [CNT_W-1:0] r_per_act, r_duty_act;
  logic [CNT_W-1:0] r_pre_cnt, r_cnt;
  logic             r_pwm, r_oe_pwm, r_period_end;

  logic             w_acc, w_addr_ok, w_wr;
  logic             w_sel_ctrl, w_sel_div, w_sel_per, w_sel_duty, w_sel_cnt;
  logic [CNT_W-1:0] w_div_m1, w_per_m1;
  logic             w_tick, w_wrap, w_shadow_ld;
  logic             w_unused_pwdata;

  assign w_acc      = psel & penable;
  assign w_addr_ok  = (paddr[1:0] == 2'b00) & (paddr <= ADDR_W'(16));
  assign w_sel_ctrl = w_addr_ok & (paddr == ADDR_W'(0));
  assign w_sel_div  = w_addr_ok & (paddr == ADDR_W'(4));
  assign w_sel_per  = w_addr_ok & (paddr == ADDR_W'(8));
  assign w_sel_duty = w_addr_ok & (paddr == ADDR_W'(12));
  assign w_sel_cnt  = w_addr_ok & (paddr == ADDR_W'(16));

  assign pready  = psel;
  assign pslverr = w_acc & (~w_addr_ok | (pwrite & w_sel_cnt));
  assign w_wr    = w_acc & pwrite & ~pslverr;

  // Upper write-data bits are intentionally discarded.
  assign w_unused_pwdata = ^pwdata;

  // Read mux: zero-extended register readback, 0 for writes and bad addresses.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite && w_addr_ok) begin
      if (w_sel_ctrl)      prdata[2:0]       = {r_sync, r_oe, r_en};
      else if (w_sel_div)  prdata[CNT_W-1:0] = r_div;
      else if (w_sel_per)  prdata[CNT_W-1:0] = r_per;
      else if (w_sel_duty) prdata[CNT_W-1:0] = r_duty;
      else                 prdata[CNT_W-1:0] = r_cnt;
    end
  end

  // Register writes commit on the edge that ends the access cycle.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      r_en   <= 1'b0;
      r_oe   <= 1'b0;
      r_sync <= 1'b0;
      r_div  <= '0;
      r_per  <= '0;
      r_duty <= '0;
    end else if (w_wr) begin
      if (w_sel_ctrl) {r_sync, r_oe, r_en} <= pwdata[2:0];
      if (w_sel_div)  r_div  <= pwdata[CNT_W-1:0];
      if (w_sel_per)  r_per  <= pwdata[CNT_W-1:0];
      if (w_sel_duty) r_duty <= pwdata[CNT_W-1:0];
    end
  end

  assign w_div_m1 = (r_div == '0) ? '0 : r_div - CNT_W'(1);
  assign w_tick   = r_en & (r_pre_cnt == w_div_m1);
  assign w_per_m1 = r_per_act - CNT_W'(1);
  // >= rather than == so a shrunk period wraps on the next tick.
  assign w_wrap   = w_tick & (r_per_act != '0) & (r_cnt >= w_per_m1);

  // A zero active period never wraps, so it is reloaded every cycle to
  // avoid getting stuck at 0 in SYNC mode.
  assign w_shadow_ld = ~r_en | ~r_sync | w_wrap | (r_per_act == '0);

  // Prescaler; a divisor cut below the current count restarts it without a tick.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l)                          r_pre_cnt <= '0;
    else if (!r_en)                        r_pre_cnt <= '0;
    else if (w_tick || r_pre_cnt > w_div_m1) r_pre_cnt <= '0;
    else                                   r_pre_cnt <= r_pre_cnt + CNT_W'(1);
  end

  // Period counter, held at 0 when disabled or when the period is zero.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l)                            r_cnt <= '0;
    else if (!r_en || r_per_act == '0 || w_wrap) r_cnt <= '0;
    else if (w_tick)                         r_cnt <= r_cnt + CNT_W'(1);
  end

  // Active period/duty shadows: track registers, or load at wrap in SYNC mode.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      r_per_act  <= '0;
      r_duty_act <= '0;
    end else if (w_shadow_ld) begin
      r_per_act  <= r_per;
      r_duty_act <= r_duty;
    end
  end

  // Registered outputs so o_pwm and period_end are glitch-free.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      r_pwm        <= 1'b0;
      r_oe_pwm     <= 1'b0;
      r_period_end <= 1'b0;
    end else begin
      r_pwm        <= r_en & (r_per_act != '0) & (r_cnt < r_duty_act);
      r_oe_pwm     <= r_oe;
      r_period_end <= w_wrap;
    end
  end

  assign o_pwm      = r_pwm;
  assign oe_pwm     = r_oe_pwm;
  assign period_end = r_period_end;

endmodule

// File: tb/tb_apb_pwm_responder.sv
// Directed self-checking bench for apb_pwm_responder.
module tb_apb_pwm_responder;

  logic        clk_i = 1'b0;
  logic        reset_l = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, o_pwm, oe_pwm, period_end;

  apb_pwm_responder #(.CNT_W(16), .ADDR_W(8)) dut (
    .clk_i(clk_i), .reset_l(reset_l), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .o_pwm(o_pwm), .oe_pwm(oe_pwm),
    .period_end(period_end)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] rd;
  logic        er;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // PWM edge / period_end monitor, sampled on the falling clock edge.
  int   cyc = 0, t_edge = -1, hi_w = 0, lo_w = 0, t_pe = -1, pe_gap = 0;
  logic prev = 1'b0;
  always @(negedge clk_i) begin
    cyc++;
    if (o_pwm !== prev) begin
      if (t_edge >= 0) begin
        if (prev) hi_w = cyc - t_edge;
        else      lo_w = cyc - t_edge;
      end
      t_edge = cyc;
      prev = o_pwm;
    end
    if (period_end) begin
      if (t_pe >= 0) pe_gap = cyc - t_pe;
      t_pe = cyc;
    end
  end

  task automatic mon_clr();
    t_edge = -1; t_pe = -1; hi_w = 0; lo_w = 0; pe_gap = 0; prev = o_pwm;
  endtask

  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_i);
    psel = 1'b1; penable = 1'b1; pwrite = w; paddr = a; pwdata = d;
    #1;
    rd = prdata;
    er = pslverr;
  endtask

  task automatic idle();
    @(negedge clk_i);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wait_pe(input string tag, input int lim);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk_i);
      if (period_end) seen = 1'b1;
    end
    #2;
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_pwm(input string tag, input logic v, input int lim);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk_i);
      if (o_pwm === v) seen = 1'b1;
    end
    #2;
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic count_win(input int n, output int hi, output int pe);
    hi = 0; pe = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (o_pwm) hi++;
      if (period_end) pe++;
    end
  endtask

  logic [7:0]  wr_addr [4] = '{8'h08, 8'h04, 8'h0C, 8'h00};
  logic [31:0] wr_data [4] = '{32'd200, 32'd2, 32'd37, 32'd7};
  logic [7:0]  rd_addr [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};

  initial begin
    int hi, pe;

    // 1: reset values
    repeat (3) @(negedge clk_i);
    reset_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, rd_addr[i], 32'd0);
      chk($sformatf("t1_rd_%0h", rd_addr[i]), rd, 32'd0);
      chk($sformatf("t1_err_%0h", rd_addr[i]), {31'b0, er}, 32'd0);
    end
    chk("t1_pready", {31'b0, pready}, 32'd1);
    chk("t1_pwm", {31'b0, o_pwm}, 32'd0);
    chk("t1_oe", {31'b0, oe_pwm}, 32'd0);

    // 2: continuous back-to-back rewrites must not disturb the waveform
    mon_clr();
    for (int i = 0; i < 1400; i++) bus(1'b1, wr_addr[i % 4], wr_data[i % 4]);
    idle();
    #2;
    chk("t2_hi_w", hi_w, 32'd74);
    chk("t2_lo_w", lo_w, 32'd326);
    chk("t2_pe_gap", pe_gap, 32'd400);
    chk("t2_oe", {31'b0, oe_pwm}, 32'd1);

    // 3a: SYNC=1 duty change mid-period
    wait_pe("t3_pe_a", 500);
    repeat (20) @(negedge clk_i);
    bus(1'b0, 8'h10, 32'd0);
    chk("t3_count", rd, 32'd10);
    bus(1'b1, 8'h0C, 32'd222);
    idle();
    wait_pwm("t3_fall", 1'b0, 200);
    chk("t3_keep_hi", hi_w, 32'd74);
    wait_pe("t3_pe_b", 500);
    @(negedge clk_i);
    count_win(800, hi, pe);
    chk("t3_const1", hi, 32'd800);

    // 3b: SYNC=0 duty change applies immediately
    bus(1'b1, 8'h00, 32'd3);
    idle();
    wait_pe("t3_pe_c", 500);
    repeat (100) @(negedge clk_i);
    chk("t3_pre_hi", {31'b0, o_pwm}, 32'd1);
    bus(1'b1, 8'h0C, 32'd37);
    idle();
    repeat (2) @(negedge clk_i);
    chk("t3_imm_lo", {31'b0, o_pwm}, 32'd0);
    wait_pe("t3_pe_d", 500);
    wait_pwm("t3_rise", 1'b1, 10);
    wait_pwm("t3_fall2", 1'b0, 200);
    chk("t3_async_hi", hi_w, 32'd74);

    // 4: DUTY=0, then PERIOD=0
    bus(1'b1, 8'h0C, 32'd0);
    idle();
    repeat (4) @(negedge clk_i);
    count_win(450, hi, pe);
    chk("t4_duty0_hi", hi, 32'd0);
    bus(1'b1, 8'h08, 32'd0);
    bus(1'b1, 8'h0C, 32'd37);
    idle();
    repeat (4) @(negedge clk_i);
    count_win(450, hi, pe);
    chk("t4_per0_hi", hi, 32'd0);
    chk("t4_per0_pe", pe, 32'd0);
    bus(1'b0, 8'h10, 32'd0);
    chk("t4_count0", rd, 32'd0);

    // 5: write-data masking and error responses
    bus(1'b1, 8'h04, 32'hFFFF_0003);
    chk("t5_wr_err", {31'b0, er}, 32'd0);
    bus(1'b1, 8'h00, 32'hFFFF_FFFF);
    idle();
    @(negedge clk_i);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h14;
    #1;
    chk("t5_setup_err", {31'b0, pslverr}, 32'd0);
    bus(1'b1, 8'h10, 32'd5);
    chk("t5_err_10", {31'b0, er}, 32'd1);
    bus(1'b1, 8'h06, 32'h55);
    chk("t5_err_06", {31'b0, er}, 32'd1);
    bus(1'b0, 8'h14, 32'd0);
    chk("t5_err_14", {31'b0, er}, 32'd1);
    chk("t5_rd_14", rd, 32'd0);
    bus(1'b0, 8'h00, 32'd0); chk("t5_ctrl", rd, 32'd7);
    bus(1'b0, 8'h04, 32'd0); chk("t5_div", rd, 32'd3);
    bus(1'b0, 8'h08, 32'd0); chk("t5_per", rd, 32'd0);
    bus(1'b0, 8'h0C, 32'd0); chk("t5_duty", rd, 32'd37);
    bus(1'b0, 8'h10, 32'd0); chk("t5_count", rd, 32'd0);

    // 6: asynchronous reset while o_pwm is high
    bus(1'b1, 8'h04, 32'd2);
    bus(1'b1, 8'h08, 32'd200);
    idle();
    wait_pwm("t6_rise", 1'b1, 50);
    reset_l = 1'b0;
    #1;
    chk("t6_async_pwm", {31'b0, o_pwm}, 32'd0);
    chk("t6_async_oe", {31'b0, oe_pwm}, 32'd0);
    repeat (2) @(negedge clk_i);
    reset_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, rd_addr[i], 32'd0);
      chk($sformatf("t6_rd_%0h", rd_addr[i]), rd, 32'd0);
    end
    idle();
    count_win(100, hi, pe);
    chk("t6_no_out", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
